// File: rtl/if_fetch_pkg.sv
// Shared configuration for the instruction fetch slice: bus widths, cache
// geometry, pc field positions and the fetch FSM encoding.
package if_fetch_pkg;

  localparam int AddrBus        = 32;
  localparam int InstBus        = 32;
  localparam int ICACHE_ENTRIES = 128;

  localparam int IdxLsb = 2;
  localparam int IdxMsb = 8;
  localparam int TagLsb = 9;
  localparam int TagMsb = 17;
  localparam int IdxW   = IdxMsb - IdxLsb + 1;
  localparam int TagW   = TagMsb - TagLsb + 1;

  localparam logic               Enable   = 1'b1;
  localparam logic               Disable  = 1'b0;
  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Memory is word addressed: the byte offset is always forced to zero.
  function automatic logic [AddrBus-1:0] word_addr(input logic [AddrBus-1:2] pc_word);
    return {pc_word, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_icache_mem.sv
// Direct-mapped instruction cache storage: valid/tag/data arrays with a
// combinational lookup port and a synchronous fill port.
module icache_mem
  import if_fetch_pkg::*;
#(
  parameter int ENTRIES = ICACHE_ENTRIES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [IdxW-1:0]    rd_idx_i,
  input  logic [TagW-1:0]    rd_tag_i,
  output logic               hit_o,
  output logic [InstBus-1:0] rd_data_o,
  input  logic               wr_en_i,
  input  logic [IdxW-1:0]    wr_idx_i,
  input  logic [TagW-1:0]    wr_tag_i,
  input  logic [InstBus-1:0] wr_data_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [TagW-1:0]    tag_q  [ENTRIES];
  logic [InstBus-1:0] data_q [ENTRIES];

  // Lookup sees the arrays before any same-cycle fill lands.
  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

  // Valid bits: cleared by reset, set by a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {ENTRIES{1'b0}};
    end else if (rdy && wr_en_i) begin
      valid_q[wr_idx_i] <= Enable;
    end
  end

  // Tag and data payload written alongside the valid bit.
  always_ff @(posedge clk) begin
    if (!rst && rdy && wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: serves hits from the icache with one-cycle latency
// and runs a single outstanding miss fill against memory.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_ENTRIES = if_fetch_pkg::ICACHE_ENTRIES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [AddrBus-1:0] pc_i,
  input  logic               stall_i,
  input  logic               jump_enable_i,
  output logic               icache_hit_o,
  output logic               inst_finished_o,
  output logic               inst_valid_o,
  output logic [InstBus-1:0] inst_o,
  output logic [AddrBus-1:0] inst_pc_o,
  output logic               mem_req_o,
  output logic [AddrBus-1:0] mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [InstBus-1:0] mem_data_i
);

  fetch_state_e       state_q;
  logic               mem_req_q;
  logic [AddrBus-1:0] mem_addr_q;

  logic               inst_valid_q, inst_valid_d;
  logic [InstBus-1:0] inst_q, inst_d;
  logic [AddrBus-1:0] inst_pc_q, inst_pc_d;

  logic               hit_raw_s;
  logic               hit_s;
  logic               finished_s;
  logic               fill_s;
  logic [InstBus-1:0] cache_data_s;
  logic [1:0]         unused_pc_s;

  assign unused_pc_s = pc_i[1:0];

  icache_mem #(
    .ENTRIES (ICACHE_ENTRIES)
  ) u_icache_mem (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rd_idx_i  (pc_i[IdxMsb:IdxLsb]),
    .rd_tag_i  (pc_i[TagMsb:TagLsb]),
    .hit_o     (hit_raw_s),
    .rd_data_o (cache_data_s),
    .wr_en_i   (fill_s),
    .wr_idx_i  (mem_addr_q[IdxMsb:IdxLsb]),
    .wr_tag_i  (mem_addr_q[TagMsb:TagLsb]),
    .wr_data_i (mem_data_i)
  );

  assign hit_s      = hit_raw_s & ~rst;
  assign finished_s = ~rst & (state_q == BUSY) & mem_ack_i & ~stall_i & ~jump_enable_i;
  // A drained fill still lands in the cache; only the output bypass is dropped.
  assign fill_s     = ~rst & rdy & mem_ack_i & ((state_q == BUSY) | (state_q == DRAIN));

  assign icache_hit_o    = hit_s;
  assign inst_finished_o = finished_s;
  assign mem_req_o       = mem_req_q;
  assign mem_addr_o      = mem_addr_q;
  assign inst_valid_o    = inst_valid_q;
  assign inst_o          = inst_q;
  assign inst_pc_o       = inst_pc_q;

  // Miss-fill FSM with registered memory request and address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= Disable;
      mem_addr_q <= ZeroWord;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (!hit_s && !jump_enable_i) begin
            state_q    <= BUSY;
            mem_req_q  <= Enable;
            mem_addr_q <= word_addr(pc_i[AddrBus-1:2]);
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= Disable;
          end else if (jump_enable_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= Disable;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= Disable;
        end
      endcase
    end
  end

  // Output selection: jump beats stall, stall beats fill bypass and hit.
  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (jump_enable_i) begin
      inst_valid_d = Disable;
    end else if (stall_i) begin
      inst_valid_d = inst_valid_q;
    end else if (finished_s) begin
      inst_valid_d = Enable;
      inst_d       = mem_data_i;
      inst_pc_d    = mem_addr_q;
    end else if (hit_s) begin
      inst_valid_d = Enable;
      inst_d       = cache_data_s;
      inst_pc_d    = pc_i;
    end else begin
      inst_valid_d = Disable;
    end
  end

  // Fetch result registers toward decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid_q <= Disable;
      inst_q       <= ZeroWord;
      inst_pc_q    <= ZeroWord;
    end else if (rdy) begin
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule
